fas_frame_ctrl: RTL and testbench

Frame scheduler for the FAS datapath; sits between the FIR output stage and the shared 16-point FFT core and analysis unit.
- Steers FIR samples into a two-bank ping-pong frame buffer.
- Starts the FFT on each full bank and reports per-frame fft_valid.
- After the last frame, triggers the frequency-analysis stage and raises done.

---
 rtl/fas_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fas_frame_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fas_frame_ctrl.sv
// FAS frame scheduler: steers FIR samples into a ping-pong frame buffer,
// sequences the shared FFT over each full bank and triggers the final analysis.
module fas_frame_ctrl #(
   parameter int FRAME_LEN  = 16,
   parameter int NUM_FRAMES = 64,
   localparam int AW = $clog2(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fir_valid,
   output logic          wr_en,
   output logic          wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic          fft_start,
   output logic          fft_bank,
   input  logic          fft_done,
   output logic          fft_valid,
   output logic          ana_start,
   input  logic          ana_done,
   output logic          done,
   output logic [6:0]    frame_cnt,
   output logic          overrun
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_RUN   = 3'd2,
      S_OUT   = 3'd3,
      S_ANA   = 3'd4,
      S_AWAIT = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   logic          r_wr_bank;
   logic [AW-1:0] r_wr_addr;
   logic [1:0]    r_full;
   logic [6:0]    r_wr_frames;
   logic          r_overrun;

   state_t        r_state;
   logic          r_rd_bank;
   logic          r_fft_start;
   logic          r_fft_bank;
   logic          r_fft_valid;
   logic          r_ana_start;
   logic          r_done;
   logic [6:0]    r_frame_cnt;

   logic          w_more;
   logic          w_bank_full;
   logic          w_wr_en;
   logic          w_last;
   logic          w_fill;
   logic          w_clr;
   logic [1:0]    w_set_v;
   logic [1:0]    w_clr_v;
   logic [1:0]    w_full_nxt;
   logic [6:0]    w_cnt_inc;

   assign w_more      = (r_wr_frames < 7'(NUM_FRAMES));
   assign w_bank_full = r_full[r_wr_bank];
   assign w_wr_en     = fir_valid & ~w_bank_full & w_more;
   assign w_last      = (r_wr_addr == AW'(FRAME_LEN - 1));
   assign w_fill      = w_wr_en & w_last;
   assign w_clr       = (r_state == S_OUT);
   assign w_cnt_inc   = r_frame_cnt + 7'd1;

   // Set and clear never target the same bank in one cycle, so the order here is moot.
   assign w_set_v    = {w_fill & r_wr_bank, w_fill & ~r_wr_bank};
   assign w_clr_v    = {w_clr & r_rd_bank, w_clr & ~r_rd_bank};
   assign w_full_nxt = (r_full & ~w_clr_v) | w_set_v;

   // Write side: sample address, bank steering, full flags and sticky overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_bank   <= 1'b0;
         r_wr_addr   <= '0;
         r_full      <= 2'b00;
         r_wr_frames <= 7'd0;
         r_overrun   <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_wr_en) begin
            if (w_last) begin
               r_wr_addr   <= '0;
               r_wr_bank   <= ~r_wr_bank;
               r_wr_frames <= r_wr_frames + 7'd1;
            end else begin
               r_wr_addr <= r_wr_addr + AW'(1);
            end
         end
         if (fir_valid && w_bank_full && w_more) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Read side FSM; each strobe is registered on entry to the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rd_bank   <= 1'b0;
         r_fft_start <= 1'b0;
         r_fft_bank  <= 1'b0;
         r_fft_valid <= 1'b0;
         r_ana_start <= 1'b0;
         r_done      <= 1'b0;
         r_frame_cnt <= 7'd0;
      end else begin
         r_fft_start <= 1'b0;
         r_fft_valid <= 1'b0;
         r_ana_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  r_state     <= S_START;
                  r_fft_start <= 1'b1;
                  r_fft_bank  <= r_rd_bank;
               end
            end
            S_START: r_state <= S_RUN;
            S_RUN: begin
               if (fft_done) begin
                  r_state     <= S_OUT;
                  r_fft_valid <= 1'b1;
               end
            end
            S_OUT: begin
               r_rd_bank <= ~r_rd_bank;
               if (r_frame_cnt < 7'(NUM_FRAMES)) begin
                  r_frame_cnt <= w_cnt_inc;
               end
               if (w_cnt_inc == 7'(NUM_FRAMES)) begin
                  r_state     <= S_ANA;
                  r_ana_start <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ANA: r_state <= S_AWAIT;
            S_AWAIT: begin
               if (ana_done) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_en     = w_wr_en;
   assign wr_bank   = r_wr_bank;
   assign wr_addr   = r_wr_addr;
   assign fft_start = r_fft_start;
   assign fft_bank  = r_fft_bank;
   assign fft_valid = r_fft_valid;
   assign ana_start = r_ana_start;
   assign done      = r_done;
   assign frame_cnt = r_frame_cnt;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Scoreboard bench for fas_frame_ctrl: a timestamp model predicts every strobe
// cycle from the write/FFT/analysis timing rules; a monitor pops and compares.
module tb_fas_frame_ctrl;
   localparam int FL    = 16;
   localparam int NF    = 64;
   localparam int TOTAL = FL * NF;

   logic       clk = 1'b0;
   logic       rst, fir_valid, fft_done, ana_done;
   logic       wr_en, wr_bank, fft_start, fft_bank, fft_valid, ana_start, done, overrun;
   logic [3:0] wr_addr;
   logic [6:0] frame_cnt;

   fas_frame_ctrl #(.FRAME_LEN(FL), .NUM_FRAMES(NF)) dut (
      .clk(clk), .rst(rst), .fir_valid(fir_valid), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_addr(wr_addr), .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
      .fft_valid(fft_valid), .ana_start(ana_start), .ana_done(ana_done), .done(done),
      .frame_cnt(frame_cnt), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int data;} ev_t;
   typedef ev_t evq_t[$];

   evq_t q_wr, q_st, q_vl, q_an, q_dn, q_ov;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic prev_done = 1'b0;
   logic prev_ovr  = 1'b0;

   // Model timestamps per frame: fill cycle, fft_start, fft_done, fft_valid.
   int f_c[NF], s_c[NF], d_c[NF], v_c[NF];
   int acc, nsched, p, a_c, ad_c, done_c;
   bit ovr_exp;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input int d);
      ev_t e;
      e.cyc  = c;
      e.data = d;
      return e;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NF; k++) begin
         f_c[k] = -1; s_c[k] = -1; d_c[k] = -1; v_c[k] = -1;
      end
      acc = 0; nsched = 0; p = 0; a_c = -1; ad_c = -1; done_c = -1; ovr_exp = 1'b0;
   endtask

   task automatic chk(input string nm, input bit seen, input int data, inout evq_t q);
      while (q.size() > 0 && q[0].cyc < cyc) begin
         n_tests++; n_fail++;
         $display("FAIL %s missing: required at cycle %0d (data %0d), got nothing", nm, q[0].cyc, q[0].data);
         void'(q.pop_front());
      end
      if (seen) begin
         n_tests++;
         if (q.size() == 0 || q[0].cyc != cyc) begin
            n_fail++;
            $display("FAIL %s unexpected at cycle %0d: got data %0d, required no pulse (next expected cycle %0d)",
                     nm, cyc, data, (q.size() > 0) ? q[0].cyc : -1);
         end else begin
            if (q[0].data != data) begin
               n_fail++;
               $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, data, q[0].data);
            end
            void'(q.pop_front());
         end
      end
   endtask

   task automatic flush(input string nm, input int upto, inout evq_t q);
      while (q.size() > 0) begin
         if (q[0].cyc <= upto) begin
            n_tests++; n_fail++;
            $display("FAIL %s missing: required at cycle %0d (data %0d), got nothing", nm, q[0].cyc, q[0].data);
         end
         void'(q.pop_front());
      end
   endtask

   task automatic flush_all(input int upto);
      flush("wr", upto, q_wr);
      flush("fft_start", upto, q_st);
      flush("fft_valid", upto, q_vl);
      flush("ana_start", upto, q_an);
      flush("done_rise", upto, q_dn);
      flush("overrun_rise", upto, q_ov);
   endtask

   // Monitor: compares every DUT strobe against the scoreboard queues.
   always @(negedge clk) begin
      chk("wr", wr_en === 1'b1, int'(wr_bank) * FL + int'(wr_addr), q_wr);
      chk("fft_start", fft_start === 1'b1, int'(fft_bank), q_st);
      chk("fft_valid", fft_valid === 1'b1, int'(fft_bank) * 128 + int'(frame_cnt), q_vl);
      chk("ana_start", ana_start === 1'b1, int'(frame_cnt), q_an);
      chk("done_rise", (done === 1'b1) && (prev_done !== 1'b1), 0, q_dn);
      chk("overrun_rise", (overrun === 1'b1) && (prev_ovr !== 1'b1), 0, q_ov);
      prev_done <= done;
      prev_ovr  <= overrun;
   end

   task automatic step(input int fv_pct, input int dmin, input int dmax, input bit stray, input bit force_fv);
      int t, j, k, st;
      bit fv, blocked, fd, ad;
      @(posedge clk); #1;
      t  = cyc;
      fv = force_fv || ($urandom_range(0, 99) < fv_pct);
      j  = acc / FL;
      blocked = (j >= 2) && (acc < TOTAL) && (v_c[j-2] < 0 || t < v_c[j-2] + 1);
      if (fv && acc < TOTAL) begin
         if (!blocked) begin
            q_wr.push_back(mk(t, (j % 2) * FL + acc % FL));
            acc++;
            if (acc % FL == 0) f_c[j] = t;
         end else if (!ovr_exp) begin
            ovr_exp = 1'b1;
            q_ov.push_back(mk(t + 1, 0));
         end
      end
      while (nsched < NF && f_c[nsched] >= 0 && (nsched == 0 || v_c[nsched-1] >= 0)) begin
         k  = nsched;
         st = f_c[k] + 2;
         if (k > 0 && v_c[k-1] + 2 > st) st = v_c[k-1] + 2;
         s_c[k] = st;
         d_c[k] = st + 1 + int'($urandom_range(dmin, dmax));
         v_c[k] = d_c[k] + 1;
         q_st.push_back(mk(s_c[k], k % 2));
         q_vl.push_back(mk(v_c[k], (k % 2) * 128 + k));
         if (k == NF - 1) begin
            a_c    = v_c[k] + 1;
            ad_c   = a_c + 1 + int'($urandom_range(0, 5));
            done_c = ad_c + 1;
            q_an.push_back(mk(a_c, NF));
            q_dn.push_back(mk(done_c, 0));
         end
         nsched++;
      end
      fd = (p < NF) && (d_c[p] == t);
      if (fd) p++;
      else if (stray && $urandom_range(0, 15) == 0 && !(p < NF && s_c[p] >= 0 && t > s_c[p])) fd = 1'b1;
      ad = (t == ad_c) || (stray && $urandom_range(0, 15) == 0 && (a_c < 0 || t <= a_c));
      fir_valid = fv;
      fft_done  = fd;
      ana_done  = ad;
   endtask

   task automatic do_reset();
      int t_rst;
      @(posedge clk); #1;
      rst = 1'b1; fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
      t_rst = cyc;
      @(posedge clk); #1;
      rst = 1'b0;
      n_tests++;
      if ({wr_en, wr_bank, wr_addr, fft_start, fft_bank, fft_valid, ana_start, done, frame_cnt, overrun} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_state: got wr_en=%b wr_bank=%b wr_addr=%0d fft_start=%b fft_bank=%b fft_valid=%b ana_start=%b done=%b frame_cnt=%0d overrun=%b, required all 0",
                  wr_en, wr_bank, wr_addr, fft_start, fft_bank, fft_valid, ana_start, done, frame_cnt, overrun);
      end
      flush_all(t_rst);
      model_reset();
      fft_done = 1'b1;
      ana_done = 1'b1;
   endtask

   task automatic run(input int fv_pct, input int dmin, input int dmax, input bit stray,
                      input int abort_frame, input int budget);
      int t0;
      bit fin;
      t0  = cyc;
      fin = 1'b0;
      while (!fin) begin
         step(fv_pct, dmin, dmax, stray, done_c >= 0 && cyc >= done_c);
         if (abort_frame >= 0 && s_c[abort_frame] >= 0 && cyc == s_c[abort_frame] + 1) begin
            do_reset();
            return;
         end else if (done_c >= 0 && cyc >= done_c + 12) begin
            fin = 1'b1;
         end else if (cyc - t0 > budget) begin
            n_tests++; n_fail++;
            $display("FAIL run_timeout: got no completion after %0d cycles, required done", budget);
            fin = 1'b1;
         end
      end
      n_tests++;
      if (done !== 1'b1 || frame_cnt !== 7'(NF) || overrun !== ovr_exp) begin
         n_fail++;
         $display("FAIL run_end: got done=%b frame_cnt=%0d overrun=%b, required done=1 frame_cnt=%0d overrun=%b",
                  done, frame_cnt, overrun, NF, ovr_exp);
      end
      fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
      @(posedge clk); #1;
      flush_all(cyc);
   endtask

   initial begin
      rst = 1'b1; fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();
      run(100, 10, 10, 1'b0, -1, 4000);
      do_reset();
      run(100, 40, 45, 1'b1, -1, 8000);
      do_reset();
      run(70, 2, 6, 1'b1, 3, 2000);
      run(60, 2, 8, 1'b1, -1, 8000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
